// File: rtl/snake_pkg.sv
// -----------------------------------------------------------------------------
// snake_pkg
// Shared definitions for the snake head scheduler:
//   COORD_W     - width of the head coordinates (10 bits)
//   dir_t       - direction encoding (0=up, 1=down, 2=left, 3=right)
//   state_t     - scheduler FSM states
//   is_reverse  - true when two directions point opposite ways
// -----------------------------------------------------------------------------
package snake_pkg;

   localparam int COORD_W = 10;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_STEP = 2'd2,
      ST_DEAD = 2'd3
   } state_t;

   // Opposite directions differ only in bit 0 (up/down, left/right).
   function automatic logic is_reverse(input dir_t a, input dir_t b);
      return ((2'(a) ^ 2'(b)) == 2'b01);
   endfunction

endpackage

// File: rtl/frame_tick_div.sv
// -----------------------------------------------------------------------------
// frame_tick_div
// Counts frame ticks and emits a one-cycle step pulse on every DIV-th counted
// tick. The pulse is combinational with the tick that completes the count,
// so the consumer registers it (the scheduler enters STEP on the next cycle).
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   tick        - frame start pulse
//   enable      - count ticks only while high
//   clear       - synchronous clear, wins over tick and suppresses the pulse
//   step        - one-cycle pulse, DIV ticks after the last clear/pulse
// -----------------------------------------------------------------------------
module frame_tick_div #(
   parameter int DIV = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick,
   input  logic enable,
   input  logic clear,
   output logic step
);

   localparam int            CW   = 8;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] count_reg;
   logic [CW-1:0] count_next;
   logic          hit;

   assign hit  = tick && enable && (count_reg == LAST);
   assign step = hit && !clear;

   always_comb begin
      count_next = count_reg;
      if (clear) begin
         count_next = '0;
      end else if (tick && enable) begin
         count_next = hit ? '0 : count_reg + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

endmodule

// File: rtl/snake_frame_sched.sv
// -----------------------------------------------------------------------------
// snake_frame_sched
// Moves the snake head one STEP every FRAMES_PER_STEP frames in the latched
// direction and reports wall collisions.
// Build option: define SNAKE_WRAP_EN to wrap the head around the play field
// instead of dying on an out-of-range move (DEAD is then unreachable).
// Ports:
//   iCLK, iRST_N    - pixel clock, asynchronous active-low reset
//   iFrame_Start    - one-cycle pulse at the start of each frame
//   iStart          - one-cycle game start/restart request
//   iPause          - level, freezes frame counting while high
//   iDir/iDir_Valid - requested direction, qualified for one cycle
//   oHead_X/oHead_Y - registered head coordinates
//   oMove_Stb       - one-cycle pulse when the head position changes
//   oCollide        - high while dead
//   oRunning        - high while the game is running
// -----------------------------------------------------------------------------
module snake_frame_sched
   import snake_pkg::*;
#(
   parameter int FRAMES_PER_STEP = 8,
   parameter int STEP            = 8,
   parameter int X_MAX           = 632,
   parameter int Y_MAX           = 472,
   parameter int START_X         = 320,
   parameter int START_Y         = 240
) (
   input  logic               iCLK,
   input  logic               iRST_N,
   input  logic               iFrame_Start,
   input  logic               iStart,
   input  logic               iPause,
   input  logic [1:0]         iDir,
   input  logic               iDir_Valid,
   output logic [COORD_W-1:0] oHead_X,
   output logic [COORD_W-1:0] oHead_Y,
   output logic               oMove_Stb,
   output logic               oCollide,
   output logic               oRunning
);

   localparam logic signed [COORD_W:0] STEP_S  = (COORD_W+1)'(STEP);
   localparam logic signed [COORD_W:0] X_MAX_S = (COORD_W+1)'(X_MAX);
   localparam logic signed [COORD_W:0] Y_MAX_S = (COORD_W+1)'(Y_MAX);
   localparam logic [COORD_W-1:0]      START_X_C = COORD_W'(START_X);
   localparam logic [COORD_W-1:0]      START_Y_C = COORD_W'(START_Y);

   state_t             state_reg,  state_next;
   dir_t               dir_reg,    dir_next;
   dir_t               pend_reg,   pend_next;
   logic [COORD_W-1:0] head_x_reg, head_x_next;
   logic [COORD_W-1:0] head_y_reg, head_y_next;
   logic               stb_reg,    stb_next;

   logic               step_due;
   logic               count_en;
   dir_t               ref_dir;

   // One extra bit, signed, so a move below zero shows up as negative.
   logic signed [COORD_W:0] cur_x, cur_y;
   logic signed [COORD_W:0] nx, ny;
   logic signed [COORD_W:0] fx, fy;
   logic                    move_ok;

   // Frames keep counting during STEP so a pulse landing there is not lost.
   assign count_en = ((state_reg == ST_RUN) || (state_reg == ST_STEP)) && !iPause;

   frame_tick_div #(
      .DIV (FRAMES_PER_STEP)
   ) u_div (
      .clk    (iCLK),
      .rst_n  (iRST_N),
      .tick   (iFrame_Start),
      .enable (count_en),
      .clear  (iStart),
      .step   (step_due)
   );

   // Candidate position along the pending direction (it becomes current in STEP).
   always_comb begin
      cur_x = {1'b0, head_x_reg};
      cur_y = {1'b0, head_y_reg};
      nx    = cur_x;
      ny    = cur_y;
      case (pend_reg)
         DIR_UP:   ny = cur_y - STEP_S;
         DIR_DOWN: ny = cur_y + STEP_S;
         DIR_LEFT: nx = cur_x - STEP_S;
         default:  nx = cur_x + STEP_S;
      endcase
   end

`ifdef SNAKE_WRAP_EN
   // Leaving one edge re-enters at the opposite edge; every move is legal.
   always_comb begin
      fx = nx;
      fy = ny;
      if (nx < 0)            fx = X_MAX_S;
      else if (nx > X_MAX_S) fx = '0;
      if (ny < 0)            fy = Y_MAX_S;
      else if (ny > Y_MAX_S) fy = '0;
   end
   assign move_ok = 1'b1;
`else
   assign fx      = nx;
   assign fy      = ny;
   assign move_ok = (nx >= 0) && (nx <= X_MAX_S) && (ny >= 0) && (ny <= Y_MAX_S);
`endif

   always_comb begin
      state_next  = state_reg;
      dir_next    = dir_reg;
      pend_next   = pend_reg;
      head_x_next = head_x_reg;
      head_y_next = head_y_reg;
      stb_next    = 1'b0;

      // In STEP the pending direction is about to become current, so a new
      // request must be checked against it rather than the outgoing one.
      ref_dir = (state_reg == ST_STEP) ? pend_reg : dir_reg;
      if (iDir_Valid && !is_reverse(dir_t'(iDir), ref_dir)) begin
         pend_next = dir_t'(iDir);
      end

      case (state_reg)
         ST_RUN: begin
            if (step_due) state_next = ST_STEP;
         end
         ST_STEP: begin
            dir_next = pend_reg;
            if (move_ok) begin
               head_x_next = fx[COORD_W-1:0];
               head_y_next = fy[COORD_W-1:0];
               stb_next    = 1'b1;
               // Back-to-back steps only happen with a divide-by-one counter.
               state_next  = step_due ? ST_STEP : ST_RUN;
            end else begin
               state_next  = ST_DEAD;
            end
         end
         default: ;
      endcase

      // Start/restart overrides anything the current state decided.
      if (iStart) begin
         state_next  = ST_RUN;
         dir_next    = DIR_RIGHT;
         pend_next   = DIR_RIGHT;
         head_x_next = START_X_C;
         head_y_next = START_Y_C;
         stb_next    = 1'b0;
      end
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_reg  <= ST_IDLE;
         dir_reg    <= DIR_RIGHT;
         pend_reg   <= DIR_RIGHT;
         head_x_reg <= START_X_C;
         head_y_reg <= START_Y_C;
         stb_reg    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         dir_reg    <= dir_next;
         pend_reg   <= pend_next;
         head_x_reg <= head_x_next;
         head_y_reg <= head_y_next;
         stb_reg    <= stb_next;
      end
   end

   assign oHead_X   = head_x_reg;
   assign oHead_Y   = head_y_reg;
   assign oMove_Stb = stb_reg;
   assign oCollide  = (state_reg == ST_DEAD);
   assign oRunning  = (state_reg == ST_RUN) || (state_reg == ST_STEP);

endmodule

// File: tb/tb_snake_frame_sched.sv
// -----------------------------------------------------------------------------
// tb_snake_frame_sched
// Self-checking bench for snake_frame_sched (default parameters). Honours
// SNAKE_WRAP_EN for the edge-of-field expectations.
// -----------------------------------------------------------------------------
module tb_snake_frame_sched;

   logic       iCLK = 1'b0;
   logic       iRST_N = 1'b0;
   logic       iFrame_Start = 1'b0;
   logic       iStart = 1'b0;
   logic       iPause = 1'b0;
   logic [1:0] iDir = 2'd0;
   logic       iDir_Valid = 1'b0;
   logic [9:0] oHead_X;
   logic [9:0] oHead_Y;
   logic       oMove_Stb;
   logic       oCollide;
   logic       oRunning;

   int n_cmp = 0;
   int n_err = 0;
   int stb_seen = 0;
   int stb_base = 0;

   localparam int OP_START  = 0;
   localparam int OP_FRAMES = 1;
   localparam int OP_DIR    = 2;
   localparam int OP_PAUSE  = 3;

   typedef struct {
      int op;
      int arg;
      int x;
      int y;
      int col;
      int run;
      int stb;
   } vec_t;

   vec_t tbl[27];

   always #5 iCLK = ~iCLK;

   snake_frame_sched dut (
      .iCLK         (iCLK),
      .iRST_N       (iRST_N),
      .iFrame_Start (iFrame_Start),
      .iStart       (iStart),
      .iPause       (iPause),
      .iDir         (iDir),
      .iDir_Valid   (iDir_Valid),
      .oHead_X      (oHead_X),
      .oHead_Y      (oHead_Y),
      .oMove_Stb    (oMove_Stb),
      .oCollide     (oCollide),
      .oRunning     (oRunning)
   );

   // Counts cycles with the move strobe high, sampled away from the active edge.
   always @(negedge iCLK) if (oMove_Stb === 1'b1) stb_seen++;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge iCLK);
         #1;
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input int x, input int y,
                            input int col, input int run, input int stb);
      $display("%s head=(%0d,%0d) collide=%0b running=%0b strobes=%0d",
               tag, oHead_X, oHead_Y, oCollide, oRunning, stb_seen - stb_base);
      chk({tag, ".x"},       int'(oHead_X), x);
      chk({tag, ".y"},       int'(oHead_Y), y);
      chk({tag, ".collide"}, int'(oCollide), col);
      chk({tag, ".running"}, int'(oRunning), run);
      chk({tag, ".strobes"}, stb_seen - stb_base, stb);
   endtask

   task automatic mark();
      stb_base = stb_seen;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         iFrame_Start = 1'b1;
         tick(1);
         iFrame_Start = 1'b0;
         tick(3);
      end
   endtask

   task automatic do_start();
      iStart = 1'b1;
      tick(1);
      iStart = 1'b0;
      tick(3);
   endtask

   task automatic do_dir(input int d);
      iDir       = 2'(d);
      iDir_Valid = 1'b1;
      tick(1);
      iDir_Valid = 1'b0;
      tick(1);
   endtask

   initial begin
      int m_x, m_y, m_dir, m_pend, m_cnt, m_state, m_pause, m_stb;
      int nx, ny, r, d;
      string tag;

      // ---------------- reset state ----------------
      tick(3);
      mark();
      check_all("reset", 320, 240, 0, 0, 0);
      iRST_N = 1'b1;
      tick(2);

      // ---------------- table-driven sequence ----------------
      tbl[0]  = '{OP_START,  0, 320, 240, 0, 1, 0};
      tbl[1]  = '{OP_FRAMES, 7, 320, 240, 0, 1, 0};
      tbl[2]  = '{OP_FRAMES, 1, 328, 240, 0, 1, 1};
      tbl[3]  = '{OP_START,  0, 320, 240, 0, 1, 0};
      tbl[4]  = '{OP_DIR,    0, 320, 240, 0, 1, 0};
      tbl[5]  = '{OP_FRAMES, 8, 320, 232, 0, 1, 1};
      tbl[6]  = '{OP_DIR,    1, 320, 232, 0, 1, 0};
      tbl[7]  = '{OP_FRAMES, 8, 320, 224, 0, 1, 1};
      tbl[8]  = '{OP_FRAMES, 3, 320, 224, 0, 1, 0};
      tbl[9]  = '{OP_PAUSE,  1, 320, 224, 0, 1, 0};
      tbl[10] = '{OP_FRAMES,20, 320, 224, 0, 1, 0};
      tbl[11] = '{OP_PAUSE,  0, 320, 224, 0, 1, 0};
      tbl[12] = '{OP_FRAMES, 4, 320, 224, 0, 1, 0};
      tbl[13] = '{OP_FRAMES, 1, 320, 216, 0, 1, 1};
      tbl[14] = '{OP_DIR,    2, 320, 216, 0, 1, 0};
      tbl[15] = '{OP_DIR,    3, 320, 216, 0, 1, 0};
      tbl[16] = '{OP_FRAMES, 8, 328, 216, 0, 1, 1};
      tbl[17] = '{OP_DIR,    2, 328, 216, 0, 1, 0};
      tbl[18] = '{OP_FRAMES, 8, 336, 216, 0, 1, 1};
      tbl[19] = '{OP_DIR,    1, 336, 216, 0, 1, 0};
      tbl[20] = '{OP_DIR,    0, 336, 216, 0, 1, 0};
      tbl[21] = '{OP_FRAMES, 8, 336, 208, 0, 1, 1};
      tbl[22] = '{OP_PAUSE,  1, 336, 208, 0, 1, 0};
      tbl[23] = '{OP_START,  0, 320, 240, 0, 1, 0};
      tbl[24] = '{OP_FRAMES, 8, 320, 240, 0, 1, 0};
      tbl[25] = '{OP_PAUSE,  0, 320, 240, 0, 1, 0};
      tbl[26] = '{OP_FRAMES, 8, 328, 240, 0, 1, 1};

      for (int i = 0; i < 27; i++) begin
         mark();
         case (tbl[i].op)
            OP_START:  do_start();
            OP_FRAMES: frames(tbl[i].arg);
            OP_DIR:    do_dir(tbl[i].arg);
            default: begin
               iPause = (tbl[i].arg != 0);
               tick(1);
            end
         endcase
         tag = $sformatf("vec%0d", i);
         check_all(tag, tbl[i].x, tbl[i].y, tbl[i].col, tbl[i].run, tbl[i].stb);
      end

      // ---------------- right wall ----------------
      do_start();
      mark();
      frames(39 * 8);
      check_all("to_right_wall", 632, 240, 0, 1, 39);
      mark();
      frames(8);
`ifdef SNAKE_WRAP_EN
      check_all("right_wrap", 0, 240, 0, 1, 1);
`else
      check_all("right_wall_hit", 632, 240, 1, 0, 0);
      mark();
      iPause = 1'b1;
      frames(2);
      iPause = 1'b0;
      frames(8);
      check_all("dead_frozen", 632, 240, 1, 0, 0);
`endif
      mark();
      do_start();
      check_all("restart", 320, 240, 0, 1, 0);

      // ---------------- top wall (underflow below zero) ----------------
      do_dir(0);
      mark();
      frames(30 * 8);
      check_all("to_top_wall", 320, 0, 0, 1, 30);
      mark();
      frames(8);
`ifdef SNAKE_WRAP_EN
      check_all("top_wrap", 320, 472, 0, 1, 1);
`else
      check_all("top_wall_hit", 320, 0, 1, 0, 0);
`endif

      // ---------------- iStart in the STEP cycle ----------------
      do_start();
      frames(8);
      frames(7);
      mark();
      iFrame_Start = 1'b1;
      tick(1);
      iFrame_Start = 1'b0;
      iStart = 1'b1;
      tick(1);
      iStart = 1'b0;
      tick(3);
      check_all("start_in_step", 320, 240, 0, 1, 0);
      mark();
      frames(7);
      check_all("after_start_7", 320, 240, 0, 1, 0);
      mark();
      frames(1);
      check_all("after_start_8", 328, 240, 0, 1, 1);

      // ---------------- frame pulse during STEP is counted ----------------
      do_start();
      frames(7);
      mark();
      iFrame_Start = 1'b1;
      tick(2);
      iFrame_Start = 1'b0;
      tick(3);
      check_all("frame_in_step", 328, 240, 0, 1, 1);
      mark();
      frames(6);
      check_all("frame_in_step_6", 328, 240, 0, 1, 0);
      mark();
      frames(1);
      check_all("frame_in_step_7", 336, 240, 0, 1, 1);

      // ---------------- reset during STEP ----------------
      do_start();
      frames(8);
      frames(7);
      iFrame_Start = 1'b1;
      tick(1);
      iFrame_Start = 1'b0;
      mark();
      iRST_N = 1'b0;
      #1;
      check_all("reset_in_step", 320, 240, 0, 0, 0);
      chk("reset_in_step.stb_now", int'(oMove_Stb), 0);
      tick(2);
      iRST_N = 1'b1;
      tick(3);
      frames(8);
      check_all("after_reset", 320, 240, 0, 0, 0);

      // ---------------- randomized against a frame-level model ----------------
      do_start();
      m_x = 320; m_y = 240; m_dir = 3; m_pend = 3;
      m_cnt = 0; m_state = 1; m_pause = 0;
      for (int k = 0; k < 500; k++) begin
         mark();
         m_stb = 0;
         r = int'($urandom_range(0, 99));
         if (r < 3) begin
            do_start();
            m_x = 320; m_y = 240; m_dir = 3; m_pend = 3;
            m_cnt = 0; m_state = 1;
            tag = $sformatf("rnd%0d start", k);
         end else if (r < 18) begin
            d = int'($urandom_range(0, 3));
            do_dir(d);
            if (d != (m_dir ^ 1)) m_pend = d;
            tag = $sformatf("rnd%0d dir%0d", k, d);
         end else if (r < 22) begin
            m_pause = ($urandom_range(0, 2) == 0) ? 1 : 0;
            iPause = (m_pause != 0);
            tick(1);
            tag = $sformatf("rnd%0d pause%0d", k, m_pause);
         end else begin
            frames(1);
            if (m_state == 1 && m_pause == 0) begin
               m_cnt++;
               if (m_cnt == 8) begin
                  m_cnt = 0;
                  m_dir = m_pend;
                  nx = m_x;
                  ny = m_y;
                  case (m_dir)
                     0: ny = ny - 8;
                     1: ny = ny + 8;
                     2: nx = nx - 8;
                     default: nx = nx + 8;
                  endcase
                  if (nx < 0 || nx > 632 || ny < 0 || ny > 472) begin
`ifdef SNAKE_WRAP_EN
                     if (nx < 0) nx = 632; else if (nx > 632) nx = 0;
                     if (ny < 0) ny = 472; else if (ny > 472) ny = 0;
                     m_x = nx; m_y = ny; m_stb = 1;
`else
                     m_state = 2;
`endif
                  end else begin
                     m_x = nx; m_y = ny; m_stb = 1;
                  end
               end
            end
            tag = $sformatf("rnd%0d frame", k);
         end
         check_all(tag, m_x, m_y, (m_state == 2) ? 1 : 0, (m_state == 1) ? 1 : 0, m_stb);
      end
      iPause = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/snake_frame_sched.md
SNAKE_FRAME_SCHED -- requirements
Module: snake_frame_sched

Interface
REQ-001 SHALL have parameter FRAMES_PER_STEP, default 8, frames between head moves (range 1..255).
REQ-002 SHALL have parameter STEP, default 8, head move distance in pixels per step.
REQ-003 SHALL have parameters X_MAX / Y_MAX, defaults 632 / 472, largest legal head coordinate; minimum legal coordinate is 0 on both axes.
REQ-004 SHALL have parameters START_X / START_Y, defaults 320 / 240, head position after start.
REQ-005 SHALL have port iCLK, input, 1, pixel clock, single clock domain.
REQ-006 SHALL have port iRST_N, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port iFrame_Start, input, 1, one-cycle pulse at the start of each frame (H_Cont==0 and V_Cont==0).
REQ-008 SHALL have port iStart, input, 1, one-cycle game start/restart request.
REQ-009 SHALL have port iPause, input, 1, level; freezes frame counting while high.
REQ-010 SHALL have port iDir, input, 2, requested direction (0=up, 1=down, 2=left, 3=right).
REQ-011 SHALL have port iDir_Valid, input, 1, qualifies iDir for one cycle.
REQ-012 SHALL have port oHead_X, output, 10, registered head X coordinate for the renderer.
REQ-013 SHALL have port oHead_Y, output, 10, registered head Y coordinate.
REQ-014 SHALL have port oMove_Stb, output, 1, one-cycle pulse when the head position changes.
REQ-015 SHALL have port oCollide, output, 1, level; high while in DEAD.
REQ-016 SHALL have port oRunning, output, 1, level; high while in RUN or STEP.

Function
REQ-017 SHALL implement states IDLE, RUN, STEP, DEAD.
REQ-018 IDLE/DEAD -> RUN on iStart: head loads START_X/START_Y, direction loads right, frame counter clears, oCollide clears.
REQ-019 In RUN, each iFrame_Start with iPause low SHALL increment the frame counter; when the counter equals FRAMES_PER_STEP-1, the counter SHALL clear and the FSM SHALL enter STEP on the next cycle.
REQ-020 In STEP, for exactly one cycle, the next position = head +/- STEP along the latched direction SHALL be computed in 11-bit signed arithmetic, so that underflow below 0 is detectable.
REQ-021 If the next position is within [0, X_MAX] x [0, Y_MAX]: the head SHALL update, oMove_Stb SHALL pulse in the same registered cycle, and the FSM SHALL return to RUN.
REQ-022 If the next position is out of range: the head SHALL hold, the FSM SHALL enter DEAD, oCollide SHALL assert, and oMove_Stb SHALL stay low.
REQ-023 On iDir_Valid, iDir SHALL be latched into a pending register unless it is the reverse of the current direction, in which case it is ignored; the pending direction becomes current only in STEP.
REQ-024 Several iDir_Valid pulses between steps: the last non-reversing one SHALL win.
REQ-025 iStart in RUN or STEP SHALL restart as in REQ-018; iStart has priority over a simultaneous STEP update.
REQ-026 iFrame_Start arriving during STEP SHALL still be counted, with no pulse lost.
REQ-027 iPause SHALL be ignored in IDLE and DEAD; pause takes effect on frame counting only.

Reset
REQ-028 On iRST_N low, asynchronously: state IDLE; oHead_X=START_X; oHead_Y=START_Y; direction right; pending direction right; counter 0; oMove_Stb, oCollide and oRunning 0.
REQ-029 Reset asserted mid-STEP SHALL discard the step with no oMove_Stb pulse; after release the block SHALL wait in IDLE for iStart.

Configuration
REQ-030 Macro SNAKE_WRAP_EN: when defined, an out-of-range move SHALL wrap (below 0 -> X_MAX/Y_MAX; above max -> 0), oMove_Stb SHALL pulse, and DEAD SHALL be unreachable. When undefined, REQ-022 applies.

Structure
REQ-031 A shared package snake_pkg SHALL hold the direction encodings, the FSM state type, and the coordinate width constant (10).
REQ-032 The frame counter SHALL be sub-module frame_tick_div (inputs: tick, enable, clear; output: one-cycle step pulse).

Verification
REQ-033 Reset, then iStart, then 8 iFrame_Start pulses -> one oMove_Stb; head (328,240).
REQ-034 iDir=0 valid, then 8 frames -> head (320,232); a following iDir=1 is ignored (reverse); after the next step -> (320,224).
REQ-035 Head X=632 moving right, step due -> oCollide=1, head holds 632, no oMove_Stb; with SNAKE_WRAP_EN -> head X=0, oMove_Stb=1.
REQ-036 iPause high across 20 frames -> no oMove_Stb, counter unchanged; release -> step after the remaining frames.
REQ-037 iStart in the same cycle as STEP -> head = (320,240), no oMove_Stb, counter 0.
REQ-038 iRST_N low during STEP -> outputs at reset values immediately; no pulse after release.
